nios_debug_scan_master: RTL and testbench
=========================================

# nios_debug_scan_master

Host-side initiator for the Nios II on-chip debug slave's virtual-JTAG link. It accepts a debug command (2-bit IR plus 38-bit data register image) over a valid/ready port and sequences the virtual JTAG strobes toward the debug slave's TCK-domain logic: update-IR, capture-DR, 38 shift-DR bits, update-DR and run-test-idle. It returns the 38 bits shifted out on tdo as a response. It sits between a test/bring-up controller and the debug slave in simulation and FPGA-internal self-test builds, replacing the physical JTAG hub.

## Interface
- HALF_PERIOD, 2: clk cycles per tck half-period; legal range 1..255.
- RTI_PERIODS, 1: tck periods spent in run-test-idle after update-DR; legal range 1..15.
- DR_WIDTH, 38: shift length; fixed at 38 to match jdo/sr.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master idle and able to accept.
- cmd_ir  in  2  instruction to present on ir_in.
- cmd_data  in  38  DR image, shifted out LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  38  bits captured from tdo; bit i = bit sampled in shift period i.
- rsp_ir_out  out  2  ir_out sampled during the update-IR period.
- tck  out  1  generated test clock; low when idle.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  2  instruction register value to slave.
- ir_out  in  2  slave status IR.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual state strobes.
- jtag_state_rti  out  1  run-test-idle indicator.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
- IDLE: cmd_ready=1; tck=0; all strobes 0. On cmd_valid&&cmd_ready: latch cmd_data into shift register, drive ir_in=cmd_ir, go to UIR.
- Every non-IDLE/RESP state lasts whole tck periods. A period is HALF_PERIOD cycles with tck=0, then HALF_PERIOD cycles with tck=1. State, tdi and strobes change only at period boundaries, i.e. the falling edge of tck.
- UIR: 1 period, vs_uir=1. ir_out is sampled at the tck rising edge into rsp_ir_out.
- CDR: 1 period, vs_cdr=1.
- SDR: 38 periods, vs_sdr=1. Period i: tdi=cmd_data[i]. tdo is sampled at the rising edge into rsp_data[i]. A 6-bit bit counter runs 0..37; the state exits after bit 37.
- UDR: 1 period, vs_udr=1.
- RTI: RTI_PERIODS periods, jtag_state_rti=1.
- RESP: tck=0, rsp_valid=1. rsp_data and rsp_ir_out are stable. The state exits to IDLE on rsp_ready, in the same cycle rsp_valid is sampled high with rsp_ready.
- ir_in holds the last accepted cmd_ir until the next command.
- cmd_valid outside IDLE is ignored; it is not queued.
- Exactly one strobe among vs_* and jtag_state_rti is high in any cycle of states UIR..RTI.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ir_out=0, tck=0, tdi=0, ir_in=0, all vs_* strobes=0, jtag_state_rti=0. State=IDLE, counters=0.
- Reset asserted mid-operation aborts the command in the next cycle. Partial rsp_data is cleared; no response is produced.
- Accept at cycle 0 → first UIR cycle at cycle 1.
- Total periods P = 41 + RTI_PERIODS.
- rsp_valid rises at cycle 1 + 2·HALF_PERIOD·P. Default: cycle 169.
- cmd_ready re-asserts the cycle after the rsp_valid&&rsp_ready handshake.
- The tdo sample point is the clk edge at which tck goes 0→1. The slave therefore must present tdo on the preceding falling edge.
- HALF_PERIOD=1: tck toggles every cycle, and the state advances every 2 cycles.

## Test plan
- Default params; slave model implementing sr <= {tdi, sr[37:1]}, tdo=sr[0], preloaded with 38'h2A_5A5A_5A5A on CDR; cmd_data=38'h15_0F0F_0F0F, cmd_ir=2 → rsp_data=38'h2A_5A5A_5A5A; slave sr ends at 38'h15_0F0F_0F0F; rsp_valid at cycle 169.
- ir_out tied to 2'b11, cmd_ir=1 → ir_in=1 during all states; rsp_ir_out=2'b11; strobe order UIR, CDR, SDR×38, UDR, RTI×1, with each strobe lasting exactly 4 cycles.
- Hold rsp_ready=0 for 20 cycles after rsp_valid → rsp_valid and rsp_data stay stable with tck=0. After rsp_ready=1, cmd_ready=1 on the next cycle.
- Pulse cmd_valid with a new command during SDR → ignored; the first response is unaffected, and the second command is accepted only after the response handshake.
- Assert reset_n=0 for one cycle at SDR bit 20 → next cycle all outputs equal their reset values; no rsp_valid. A following command completes correctly.
- HALF_PERIOD=1, RTI_PERIODS=3 → rsp_valid at cycle 1+2·44 = 89; tck period = 2 cycles.

Source files
------------

// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG scan master for the Nios II debug slave: one command = update-IR, capture-DR,
// DR_WIDTH shift-DR periods, update-DR and run-test-idle on a divided tck, then one response.
module nios_debug_scan_master #(
  parameter int HALF_PERIOD = 2,
  parameter int RTI_PERIODS = 1,
  parameter int DR_WIDTH    = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_in,
  input  logic [1:0]          ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } state_t;

  localparam logic [8:0] HALF_CYC = 9'(HALF_PERIOD);
  localparam logic [8:0] RISE_CYC = 9'(HALF_PERIOD - 1);
  localparam logic [8:0] LAST_CYC = 9'(2 * HALF_PERIOD - 1);
  localparam logic [5:0] LAST_BIT = 6'(DR_WIDTH - 1);
  localparam logic [3:0] LAST_RTI = 4'(RTI_PERIODS - 1);

  state_t              state_reg, state_next;
  logic [8:0]          cyc_reg, cyc_next;
  logic [5:0]          bit_reg, bit_next;
  logic [3:0]          rti_reg, rti_next;
  logic [DR_WIDTH-1:0] tx_reg, tx_next;
  logic [DR_WIDTH-1:0] rx_reg, rx_next;
  logic [1:0]          ir_in_reg, ir_in_next;
  logic [1:0]          ir_cap_reg, ir_cap_next;
  logic                tck_reg, tck_next;

  logic in_period;
  logic tck_rise;
  logic period_end;

  // cyc_reg counts clk cycles inside one tck period: low half first, then high half.
  assign in_period  = (state_reg != ST_IDLE) && (state_reg != ST_RESP);
  assign tck_rise   = in_period && (cyc_reg == RISE_CYC);
  assign period_end = in_period && (cyc_reg == LAST_CYC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cyc_reg    <= '0;
      bit_reg    <= '0;
      rti_reg    <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
      ir_in_reg  <= '0;
      ir_cap_reg <= '0;
      tck_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      bit_reg    <= bit_next;
      rti_reg    <= rti_next;
      tx_reg     <= tx_next;
      rx_reg     <= rx_next;
      ir_in_reg  <= ir_in_next;
      ir_cap_reg <= ir_cap_next;
      tck_reg    <= tck_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    bit_next    = bit_reg;
    rti_next    = rti_reg;
    tx_next     = tx_reg;
    rx_next     = rx_reg;
    ir_in_next  = ir_in_reg;
    ir_cap_next = ir_cap_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next  = ST_UIR;
          cyc_next    = '0;
          bit_next    = '0;
          rti_next    = '0;
          tx_next     = cmd_data;
          rx_next     = '0;
          ir_in_next  = cmd_ir;
          ir_cap_next = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: begin
        cyc_next = period_end ? 9'd0 : cyc_reg + 9'd1;
        // tdo/ir_out are taken on the clk edge that raises tck; the slave drove them on the fall.
        if (tck_rise && (state_reg == ST_UIR)) ir_cap_next = ir_out;
        if (tck_rise && (state_reg == ST_SDR)) rx_next = {tdo, rx_reg[DR_WIDTH-1:1]};
        if (period_end) begin
          if (state_reg == ST_UIR) begin
            state_next = ST_CDR;
          end else if (state_reg == ST_CDR) begin
            state_next = ST_SDR;
          end else if (state_reg == ST_SDR) begin
            tx_next = tx_reg >> 1;
            if (bit_reg == LAST_BIT) begin
              state_next = ST_UDR;
              bit_next   = '0;
            end else begin
              bit_next = bit_reg + 6'd1;
            end
          end else if (state_reg == ST_UDR) begin
            state_next = ST_RTI;
          end else begin
            if (rti_reg == LAST_RTI) begin
              state_next = ST_RESP;
              rti_next   = '0;
            end else begin
              rti_next = rti_reg + 4'd1;
            end
          end
        end
      end
    endcase
    // tck is registered from next-state values so the pin never glitches.
    tck_next = (state_next != ST_IDLE) && (state_next != ST_RESP) && (cyc_next >= HALF_CYC);
  end

  always_comb begin
    cmd_ready      = (state_reg == ST_IDLE);
    rsp_valid      = (state_reg == ST_RESP);
    vs_uir         = (state_reg == ST_UIR);
    vs_cdr         = (state_reg == ST_CDR);
    vs_sdr         = (state_reg == ST_SDR);
    vs_udr         = (state_reg == ST_UDR);
    jtag_state_rti = (state_reg == ST_RTI);
    tdi            = (state_reg == ST_SDR) && tx_reg[0];
    tck            = tck_reg;
    ir_in          = ir_in_reg;
    rsp_data       = rx_reg;
    rsp_ir_out     = ir_cap_reg;
  end

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Scoreboarded bench for nios_debug_scan_master with behavioural debug-slave shift registers;
// a second instance covers HALF_PERIOD=1 / RTI_PERIODS=3.
module tb_nios_debug_scan_master;
  localparam int DW = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]    cmd_ir, rsp_ir_out, ir_in, ir_out;
  logic [DW-1:0] cmd_data, rsp_data;
  logic          tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

  logic          cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2;
  logic [1:0]    cmd_ir2, rsp_ir_out2, ir_in2, ir_out2;
  logic [DW-1:0] cmd_data2, rsp_data2;
  logic          tck2, tdi2, tdo2, vs_uir2, vs_cdr2, vs_sdr2, vs_udr2, jtag_state_rti2;

  nios_debug_scan_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi), .tdo(tdo),
    .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
    .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
  );

  nios_debug_scan_master #(.HALF_PERIOD(1), .RTI_PERIODS(3), .DR_WIDTH(38)) dut2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_ir(cmd_ir2), .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_data(rsp_data2), .rsp_ir_out(rsp_ir_out2), .tck(tck2), .tdi(tdi2), .tdo(tdo2),
    .ir_in(ir_in2), .ir_out(ir_out2), .vs_uir(vs_uir2), .vs_cdr(vs_cdr2), .vs_sdr(vs_sdr2),
    .vs_udr(vs_udr2), .jtag_state_rti(jtag_state_rti2)
  );

  // Debug-slave models: capture preload on CDR, shift toward bit 0 on each SDR tck rise.
  logic [DW-1:0] slave_sr = '0, slave_preload = '0;
  logic [DW-1:0] slave2_sr = '0, slave2_preload = '0;
  always @(posedge tck) begin
    if (vs_cdr) slave_sr <= slave_preload;
    else if (vs_sdr) slave_sr <= {tdi, slave_sr[DW-1:1]};
  end
  always @(posedge tck2) begin
    if (vs_cdr2) slave2_sr <= slave2_preload;
    else if (vs_sdr2) slave2_sr <= {tdi2, slave2_sr[DW-1:1]};
  end
  assign tdo  = slave_sr[0];
  assign tdo2 = slave2_sr[0];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    irout;
    int            lat;
  } exp_t;
  exp_t sb_q[$];

  // ---------------- monitor / scoreboard (dut, default parameters) ----------------
  int            edge_cnt = 0;
  int            acc_edge = 0;
  int            m_c, m_p, m_ph;
  bit            active = 0, rsp_seen = 0, hs_pend = 0;
  int            wave_err = 0, stall_err = 0;
  logic [1:0]    m_ir;
  logic [DW-1:0] m_data, snap_data;
  logic [1:0]    snap_ir;
  logic [4:0]    exp_strb;
  exp_t          m_e;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      active = 0; rsp_seen = 0; hs_pend = 0; wave_err = 0; stall_err = 0;
    end else begin
      if (hs_pend) begin
        chk("ready_after_hs", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        chk("resp_hold", 64'(stall_err), 64'd0);
        chk("wave", 64'(wave_err), 64'd0);
        hs_pend = 0; active = 0; rsp_seen = 0; wave_err = 0; stall_err = 0;
      end
      if (cmd_valid && cmd_ready) begin
        acc_edge = edge_cnt + 1;
        active   = 1;
        m_ir     = cmd_ir;
        m_data   = cmd_data;
      end
      m_c = active ? (edge_cnt - acc_edge + 1) : -1;
      if (active && !rsp_seen && m_c >= 1 && m_c <= 168) begin
        m_p  = (m_c - 1) / 4;
        m_ph = (m_c - 1) % 4;
        exp_strb = (m_p == 0) ? 5'b10000 : (m_p == 1) ? 5'b01000 :
                   (m_p <= 39) ? 5'b00100 : (m_p == 40) ? 5'b00010 : 5'b00001;
        if ({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti} !== exp_strb) wave_err++;
        if (tck !== 1'(m_ph >= 2)) wave_err++;
        if (ir_in !== m_ir) wave_err++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) wave_err++;
        if (m_p >= 2 && m_p <= 39 && tdi !== m_data[m_p-2]) wave_err++;
      end
      if (rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          snap_data = rsp_data;
          snap_ir   = rsp_ir_out;
          chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            chk("latency", 64'(m_c), 64'(m_e.lat));
            chk("rsp_data", 64'(rsp_data), 64'(m_e.data));
            chk("rsp_ir_out", 64'(rsp_ir_out), 64'(m_e.irout));
          end
          $display("rsp: cycle=%0d data=%h ir_out=%0d", m_c, rsp_data, rsp_ir_out);
        end
        if (rsp_data !== snap_data || rsp_ir_out !== snap_ir || tck !== 1'b0) stall_err++;
        if (rsp_ready) hs_pend = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string name);
    chk(name, 64'({cmd_ready, rsp_valid, rsp_data, rsp_ir_out, tck, tdi, ir_in,
                   vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}), 64'({1'b1, 50'd0}));
  endtask

  task automatic run_cmd(input logic [1:0] ir, input logic [DW-1:0] data,
                         input logic [DW-1:0] pre, input logic [1:0] iro,
                         input logic [DW-1:0] exp_rsp, input int stall, input bit intrude);
    exp_t e;
    int   guard;
    e.data = exp_rsp; e.irout = iro; e.lat = 169;
    sb_q.push_back(e);
    $display("cmd: ir=%0d data=%h preload=%h stall=%0d intrude=%0d", ir, data, pre, stall, intrude);
    slave_preload = pre;
    ir_out    = iro;
    rsp_ready = (stall == 0);
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 400) begin
      tick(1);
      guard++;
    end
    chk("accept_wait", 64'(cmd_ready), 64'd1);
    tick(1);
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_ir    = ~ir;
    tick(8);
    ir_out = ~iro;
    if (intrude) begin
      tick(32);
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
    end
    guard = 0;
    while (!rsp_valid && guard < 400) begin
      tick(1);
      guard++;
    end
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    if (stall > 0) begin
      tick(stall);
      rsp_ready = 1'b1;
    end
    tick(1);
    chk("slave_sr", 64'(slave_sr), 64'(data));
    tick(1);
  endtask

  initial begin
    int cnt, tck_err;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b1; ir_out = 2'b11;
    cmd_valid2 = 1'b0; cmd_ir2 = '0; cmd_data2 = '0; rsp_ready2 = 1'b1; ir_out2 = 2'b00;
    tick(3);
    check_reset("reset_state");
    reset_n = 1'b1;
    tick(2);

    run_cmd(2'd2, 38'h15_0F0F_0F0F, 38'h2A_5A5A_5A5A, 2'b11, 38'h2A_5A5A_5A5A, 0, 1'b0);
    run_cmd(2'd1, 38'h3F_FFFF_0001, 38'h00_1234_ABCD, 2'b11, 38'h00_1234_ABCD, 20, 1'b0);
    run_cmd(2'd3, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 2'b10, 38'h15_5555_5555, 0, 1'b1);
    run_cmd(2'd0, 38'h01_8000_0001, 38'h3F_F00F_F00F, 2'b01, 38'h3F_F00F_F00F, 3, 1'b0);

    // Abort a scan with reset during SDR bit 20.
    $display("cmd: ir=2 data=2aaaaa5555 aborted by reset at SDR bit 20");
    slave_preload = 38'h3F_FFFF_FFFF;
    ir_out = 2'b11; rsp_ready = 1'b1;
    cmd_ir = 2'd2; cmd_data = 38'h2A_AAAA_5555; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(89);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_reset("reset_abort");
    cnt = 0;
    repeat (200) begin
      if (rsp_valid) cnt++;
      tick(1);
    end
    chk("no_rsp_after_abort", 64'(cnt), 64'd0);
    run_cmd(2'd1, 38'h12_3456_789A, 38'h2B_CDEF_0123, 2'b11, 38'h2B_CDEF_0123, 0, 1'b0);

    // HALF_PERIOD=1, RTI_PERIODS=3 instance.
    $display("cmd2: ir=1 data=1c89abcdef preload=3f01234567 (HALF_PERIOD=1 RTI_PERIODS=3)");
    slave2_preload = 38'h3F_0123_4567;
    ir_out2 = 2'b10; rsp_ready2 = 1'b1;
    cmd_ir2 = 2'd1; cmd_data2 = 38'h1C_89AB_CDEF; cmd_valid2 = 1'b1;
    cnt = 0;
    while (!cmd_ready2 && cnt < 400) begin
      tick(1);
      cnt++;
    end
    tick(1);
    cmd_valid2 = 1'b0;
    tck_err = 0;
    for (int k = 0; k < 8; k++) begin
      if (tck2 !== 1'(k % 2)) tck_err++;
      tick(1);
    end
    chk("hp1_tck_period", 64'(tck_err), 64'd0);
    cnt = 9;
    while (!rsp_valid2 && cnt < 400) begin
      tick(1);
      cnt++;
    end
    chk("hp1_latency", 64'(cnt), 64'd89);
    chk("hp1_rsp_data", 64'(rsp_data2), 64'(38'h3F_0123_4567));
    chk("hp1_ir_out", 64'(rsp_ir_out2), 64'(2'b10));
    tick(1);
    chk("hp1_ready_after_hs", 64'({cmd_ready2, rsp_valid2}), 64'(2'b10));
    chk("hp1_slave_sr", 64'(slave2_sr), 64'(38'h1C_89AB_CDEF));

    tick(2);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
